// File: rtl/bc1_frame_sum_0.sv
// Frame forwarder: passes FRAME_LEN words through a one-entry output register (1-cycle latency), then appends their mod-2^PAYLOAD_BITS sum.
// Backpressure: Input_1 ready only when the output register can take a word; the trailer waits for downstream ready.
module bc1_frame_sum_0 #(
  parameter int PAYLOAD_BITS = 32,
  parameter int FRAME_LEN    = 16,
  parameter int CNT_BITS     = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [PAYLOAD_BITS-1:0] Input_1_V_TDATA,
  input  logic                    Input_1_V_TVALID,
  output logic                    Input_1_V_TREADY,
  output logic [PAYLOAD_BITS-1:0] Output_1_V_TDATA,
  output logic                    Output_1_V_TVALID,
  input  logic                    Output_1_V_TREADY
);

  typedef enum logic [1:0] {IDLE, DATA, TRAILER, FLUSH} state_t;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_LEN - 1);

  state_t                  state, state_nxt;
  logic [CNT_BITS-1:0]     count;
  logic [PAYLOAD_BITS-1:0] sum;
  logic [PAYLOAD_BITS-1:0] odata;
  logic                    ovalid;
  logic                    done_q;
  logic                    ready_q;
  logic                    free;
  logic                    out_hs;
  logic                    last_word;
  logic                    in_acc;

  assign free      = !ovalid || Output_1_V_TREADY;
  assign out_hs    = ovalid && Output_1_V_TREADY;
  assign last_word = (count == LAST_IDX);

  always_comb begin
    state_nxt        = state;
    in_acc           = 1'b0;
    Input_1_V_TREADY = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) state_nxt = DATA;
      end
      DATA: begin
        Input_1_V_TREADY = free;
        in_acc           = Input_1_V_TVALID && free;
        if (in_acc && last_word) state_nxt = TRAILER;
      end
      TRAILER: begin
        if (free) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // A new load takes priority over a plain drain so back-to-back beats keep ovalid high.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count   <= '0;
      sum     <= '0;
      odata   <= '0;
      ovalid  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= in_acc && last_word;
      done_q  <= (state == FLUSH) && out_hs;
      if (state == IDLE && ap_start) begin
        count <= '0;
        sum   <= '0;
      end
      if (in_acc) begin
        odata  <= Input_1_V_TDATA;
        ovalid <= 1'b1;
        sum    <= sum + Input_1_V_TDATA;
        count  <= last_word ? '0 : count + CNT_BITS'(1);
      end else if (state == TRAILER && free) begin
        odata  <= sum;
        ovalid <= 1'b1;
      end else if (out_hs) begin
        ovalid <= 1'b0;
      end
    end
  end

  assign Output_1_V_TDATA  = odata;
  assign Output_1_V_TVALID = ovalid;
  assign ap_done           = done_q;
  assign ap_ready          = ready_q;
  assign ap_idle           = (state == IDLE);

endmodule

// File: doc/bc1_frame_sum_0.md
Name: bc1_frame_sum_0

Overview:
- Stage directly downstream of bc0_gen_0. Consumes its 32-bit Output_1 stream (after that block's stream_shell link) on Input_1.
- Forwards each frame of FRAME_LEN words unchanged on Output_1, then appends one trailer word: the modulo-2^PAYLOAD_BITS sum of the frame.
- Uses the same ap_start/ap_done/ap_idle/ap_ready block-level control as its neighbours, so the top level can run it one frame per start.

Parameters:
- PAYLOAD_BITS, 32, data width of both streams and of the trailer sum.
- FRAME_LEN, 16, data words per frame. Legal range 1..65535.
- CNT_BITS, 16, width of the word counter. Must satisfy 2^CNT_BITS > FRAME_LEN.

Ports:
- ap_clk  in  1  single clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to ap_clk at system level.
- ap_start  in  1  start one frame; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse after the trailer is accepted downstream.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse when the last data word of a frame is accepted.
- Input_1_V_TDATA  in  PAYLOAD_BITS  upstream data.
- Input_1_V_TVALID  in  1  upstream valid.
- Input_1_V_TREADY  out  1  ready to upstream.
- Output_1_V_TDATA  out  PAYLOAD_BITS  downstream data (data words, then trailer).
- Output_1_V_TVALID  out  1  downstream valid.
- Output_1_V_TREADY  in  1  downstream ready.

Behaviour:
- Reset values (async, while ap_rst_n=0): state=IDLE, count=0, sum=0, Output_1_V_TVALID=0, Output_1_V_TDATA=0, ap_done=0, ap_ready=0, ap_idle=1, Input_1_V_TREADY=0.
- Output register: one entry (odata, ovalid), which drives Output_1 directly.
  - free = !ovalid || Output_1_V_TREADY.
  - On a downstream handshake with no new load, ovalid clears.
- A transfer happens on either stream only when VALID && READY on a rising edge.
- Once TVALID is high, Output_1_V_TVALID/TDATA hold stable until the handshake.
- States:
  - IDLE:
    - ap_idle=1, Input_1_V_TREADY=0.
    - ap_start=1: count<=0, sum<=0, go to DATA.
  - DATA:
    - Input_1_V_TREADY=free (combinational from Output_1_V_TREADY).
    - On accept: odata<=word, ovalid<=1, sum<=sum+word (carry discarded), count<=count+1.
    - If count==FRAME_LEN-1 at accept: ap_ready pulses high the next cycle and the state goes to TRAILER.
  - TRAILER:
    - Input_1_V_TREADY=0.
    - When free: odata<=sum, ovalid<=1, go to FLUSH.
  - FLUSH:
    - Wait for the trailer handshake (ovalid && Output_1_V_TREADY).
    - Then ovalid<=0, ap_done pulses high the next cycle, and the state returns to IDLE.
- Latency and throughput:
  - A word accepted at cycle t is presented on Output_1 at t+1.
  - Throughput is 1 word/cycle with continuous downstream ready.
  - The trailer is presented at the earliest 1 cycle after the last data word.
  - A frame occupies FRAME_LEN+1 output beats.
  - The minimum gap between frames is one IDLE cycle (ap_start sampled the cycle ap_done is high).
- Boundaries:
  - ap_start outside IDLE: ignored, no effect.
  - FRAME_LEN=1: DATA accepts one word, then goes straight to TRAILER; trailer equals that word.
  - Sum wraps modulo 2^PAYLOAD_BITS.
  - count never exceeds FRAME_LEN-1.
  - Input_1_V_TVALID gaps stall DATA without any change of state.
  - Simultaneous downstream handshake and new load in the same cycle: the load wins and ovalid stays 1 (full rate).
  - Reset mid-frame: partial frame abandoned, Output_1_V_TVALID drops immediately, no trailer, no ap_done; the next frame starts clean.
- ap_done and ap_ready are never high in the same cycle. ap_done is never high in IDLE except in the return cycle.

Test Plan:
- FRAME_LEN=4; start; inputs 1,2,3,4 with TREADY=1 -> outputs 1,2,3,4,0x0000000A on consecutive cycles. ap_ready pulses once (cycle after word 4 accepted), then ap_done pulses once, then ap_idle=1.
- FRAME_LEN=2; inputs 0xFFFFFFFF, 0x00000002 -> trailer 0x00000001 (wrap-around).
- FRAME_LEN=4; hold Output_1_V_TREADY=0 for 5 cycles mid-frame -> Input_1_V_TREADY=0 and Output_1 TDATA/TVALID stable throughout. Resuming gives no loss or duplication and the correct sum.
- No ap_start, Input_1_V_TVALID=1 with data 0x55 -> Input_1_V_TREADY stays 0, Output_1_V_TVALID stays 0. An ap_start pulsed during DATA changes nothing.
- Assert ap_rst_n=0 asynchronously after 2 of 4 words -> Output_1_V_TVALID drops within the same cycle. The next frame 5,6,7,8 yields trailer 0x0000001A.
- FRAME_LEN=1 build; input 0x12345678 -> outputs 0x12345678 then 0x12345678, followed by ap_done.
